// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB definitions: response and transfer-type encodings and the number
// of bus masters addressed by HMASTER / HSPLITx.
// ---------------------------------------------------------------------------
package ahb_pkg;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam int AHB_NUM_MASTERS = 16;

endpackage

// File: rtl/ahb_split_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_split_ctrl
// Split-response controller for an AHB slave in front of a resource that is
// periodically busy. Unlocked transfers arriving while the resource is busy get
// a two-cycle SPLIT response and the master is recorded in a pending mask.
// Locked transfers are stalled instead, up to WAIT_LIMIT cycles, then ERRORed.
// When the resource frees and the slave is idle, all pending masters are
// released with a one-cycle pulse on HSPLITx.
//
// Ports
//   HCLK       bus clock (rising edge)
//   HRESET     asynchronous active-high reset
//   HSEL       slave select
//   HTRANS     transfer type (NONSEQ/SEQ are real transfers)
//   HREADY     bus ready; address phase sampled only when high
//   HMASTER    current master number
//   HMASTLOCK  current transfer is locked
//   busy_i     backend resource unavailable
//   HREADYOUT  slave ready
//   HRESP      OKAY / ERROR / SPLIT response
//   HSPLITx    one-cycle release pulse, one bit per master
//   pending_o  current split-pending mask
// ---------------------------------------------------------------------------
module ahb_split_ctrl
  import ahb_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic                       HSEL,
  input  logic [1:0]                 HTRANS,
  input  logic                       HREADY,
  input  logic [3:0]                 HMASTER,
  input  logic                       HMASTLOCK,
  input  logic                       busy_i,
  output logic                       HREADYOUT,
  output logic [1:0]                 HRESP,
  output logic [AHB_NUM_MASTERS-1:0] HSPLITx,
  output logic [AHB_NUM_MASTERS-1:0] pending_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPLIT1,
    ST_SPLIT2,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [8:0] LIMIT9 = 9'(WAIT_LIMIT);

  state_t                     state_q, state_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic [AHB_NUM_MASTERS-1:0] pend_q, pend_d;
  logic [AHB_NUM_MASTERS-1:0] split_q, split_d;

  htrans_t    trans;
  logic       accept;
  logic [8:0] cnt_inc;

  assign trans   = htrans_t'(HTRANS);
  assign accept  = HSEL & HREADY & ((trans == NONSEQ) || (trans == SEQ));
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      split_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      split_q <= split_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    split_d = '0;
    case (state_q)
      // ERR2 accepts the next address phase exactly like SPLIT2.
      ST_IDLE, ST_SPLIT2, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (busy_i && !HMASTLOCK) begin
            state_d = ST_SPLIT1;
            pend_d  = pend_q | (AHB_NUM_MASTERS'(1) << HMASTER);
          end else if (busy_i) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end else if (state_q == ST_IDLE && !busy_i && pend_q != '0) begin
          // Release only from IDLE so the arbiter has already masked every
          // split master before its HSPLIT bit can arrive.
          split_d = pend_q;
          pend_d  = '0;
        end
      end
      ST_SPLIT1: state_d = ST_SPLIT2;
      ST_ERR1:   state_d = ST_ERR2;
      ST_WAIT: begin
        if (!busy_i) begin
          state_d = ST_IDLE;
        end else begin
          if (cnt_q != 8'hFF) cnt_d = cnt_inc[7:0];
          if (cnt_inc >= LIMIT9) state_d = ST_ERR1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore decode: outputs depend only on registered state.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = OKAY;
    case (state_q)
      ST_SPLIT1: begin HREADYOUT = 1'b0; HRESP = SPLIT; end
      ST_SPLIT2: begin HREADYOUT = 1'b1; HRESP = SPLIT; end
      ST_WAIT:   begin HREADYOUT = 1'b0; HRESP = OKAY;  end
      ST_ERR1:   begin HREADYOUT = 1'b0; HRESP = ERROR; end
      ST_ERR2:   begin HREADYOUT = 1'b1; HRESP = ERROR; end
      default:   begin HREADYOUT = 1'b1; HRESP = OKAY;  end
    endcase
  end

  assign HSPLITx   = split_q;
  assign pending_o = pend_q;

endmodule

// File: tb/tb_ahb_split_ctrl.sv
module tb_ahb_split_ctrl;

  localparam logic [1:0] R_OK  = 2'b00;
  localparam logic [1:0] R_ERR = 2'b01;
  localparam logic [1:0] R_SPL = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HREADY = 1'b1;
  logic [3:0]  HMASTER = 4'd0;
  logic        HMASTLOCK = 1'b0;
  logic        busy_i = 1'b0;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [15:0] HSPLITx;
  logic [15:0] pending_o;

  typedef struct {
    logic        rdy;
    logic [1:0]  resp;
    logic [15:0] split;
    logic [15:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ahb_split_ctrl #(.WAIT_LIMIT(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS),
    .HREADY(HREADY), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK),
    .busy_i(busy_i), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HSPLITx(HSPLITx), .pending_o(pending_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive one address phase for the next edge and record the outputs that
  // edge must produce.
  task automatic step(input logic rst, input logic sel, input logic lock,
                      input logic busy, input logic [3:0] m,
                      input logic rdy, input logic [1:0] resp,
                      input logic [15:0] split, input logic [15:0] pend);
    exp_t e;
    @(posedge HCLK);
    #2;
    HRESET    = rst;
    HSEL      = sel;
    HTRANS    = sel ? 2'b10 : 2'b00;
    HMASTLOCK = lock;
    busy_i    = busy;
    HMASTER   = m;
    e.rdy = rdy; e.resp = resp; e.split = split; e.pend = pend;
    exp_q.push_back(e);
  endtask

  always @(posedge HCLK) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("hreadyout", 32'(HREADYOUT), 32'(e.rdy));
      check_eq("hresp",     32'(HRESP),     32'(e.resp));
      check_eq("hsplitx",   32'(HSPLITx),   32'(e.split));
      check_eq("pending",   32'(pending_o), 32'(e.pend));
    end
  end

  initial begin
    repeat (2) @(posedge HCLK);
    #1;
    check_eq("rst_rdy",   32'(HREADYOUT), 32'd1);
    check_eq("rst_resp",  32'(HRESP),     32'(R_OK));
    check_eq("rst_split", 32'(HSPLITx),   32'd0);
    check_eq("rst_pend",  32'(pending_o), 32'd0);

    // Unlocked, resource free: zero-wait OKAY
    step(0, 1, 0, 0, 4'd3, 1, R_OK, 16'h0, 16'h0);
    step(0, 1, 0, 0, 4'd3, 1, R_OK, 16'h0, 16'h0);
    step(0, 0, 0, 0, 4'd0, 1, R_OK, 16'h0, 16'h0);

    // Master 5 split, then released once busy drops
    step(0, 1, 0, 1, 4'd5, 0, R_SPL, 16'h0,    16'h0020);
    step(0, 0, 0, 1, 4'd0, 1, R_SPL, 16'h0,    16'h0020);
    step(0, 0, 0, 1, 4'd0, 1, R_OK,  16'h0,    16'h0020);
    step(0, 0, 0, 0, 4'd0, 1, R_OK,  16'h0020, 16'h0);
    step(0, 0, 0, 0, 4'd0, 1, R_OK,  16'h0,    16'h0);

    // Masters 2 and 9 back-to-back, second accepted in SPLIT2
    step(0, 1, 0, 1, 4'd2, 0, R_SPL, 16'h0,    16'h0004);
    step(0, 0, 0, 1, 4'd0, 1, R_SPL, 16'h0,    16'h0004);
    step(0, 1, 0, 1, 4'd9, 0, R_SPL, 16'h0,    16'h0204);
    step(0, 0, 0, 1, 4'd0, 1, R_SPL, 16'h0,    16'h0204);
    step(0, 0, 0, 0, 4'd0, 1, R_OK,  16'h0,    16'h0204);
    step(0, 0, 0, 0, 4'd0, 1, R_OK,  16'h0204, 16'h0);
    step(0, 0, 0, 0, 4'd0, 1, R_OK,  16'h0,    16'h0);

    // Locked transfer stalled 3 cycles then OKAY
    step(0, 1, 1, 1, 4'd7, 0, R_OK, 16'h0, 16'h0);
    step(0, 0, 0, 1, 4'd0, 0, R_OK, 16'h0, 16'h0);
    step(0, 0, 0, 1, 4'd0, 0, R_OK, 16'h0, 16'h0);
    step(0, 0, 0, 0, 4'd0, 1, R_OK, 16'h0, 16'h0);

    // Locked transfer, busy stuck: 4 wait cycles then ERROR pair
    step(0, 1, 1, 1, 4'd1, 0, R_OK,  16'h0, 16'h0);
    step(0, 0, 0, 1, 4'd0, 0, R_OK,  16'h0, 16'h0);
    step(0, 0, 0, 1, 4'd0, 0, R_OK,  16'h0, 16'h0);
    step(0, 0, 0, 1, 4'd0, 0, R_OK,  16'h0, 16'h0);
    step(0, 0, 0, 1, 4'd0, 0, R_ERR, 16'h0, 16'h0);
    step(0, 0, 0, 1, 4'd0, 1, R_ERR, 16'h0, 16'h0);
    // Accepted in ERR2 like SPLIT2: master 0 split
    step(0, 1, 0, 1, 4'd0, 0, R_SPL, 16'h0, 16'h0001);

    // Asynchronous reset in SPLIT1 with master 0 pending
    @(posedge HCLK);
    #3;
    HRESET = 1'b1;
    #1;
    check_eq("arst_rdy",   32'(HREADYOUT), 32'd1);
    check_eq("arst_resp",  32'(HRESP),     32'(R_OK));
    check_eq("arst_split", 32'(HSPLITx),   32'd0);
    check_eq("arst_pend",  32'(pending_o), 32'd0);
    step(1, 0, 0, 0, 4'd0, 1, R_OK, 16'h0, 16'h0);
    step(0, 0, 0, 0, 4'd0, 1, R_OK, 16'h0, 16'h0);
    step(0, 0, 0, 0, 4'd0, 1, R_OK, 16'h0, 16'h0);
    step(0, 0, 0, 0, 4'd0, 1, R_OK, 16'h0, 16'h0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge HCLK);
    #3;
    check_eq("drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
